mcp4921_dac_spi_axis: RTL and testbench



---
 rtl/mcp4921_dac_spi_axis_pkg.sv | 46 ++++
 rtl/mcp4921_dac_spi_axis_if.sv | 22 ++
 rtl/mcp4921_dac_spi_axis_half_tick.sv | 29 ++
 rtl/mcp4921_dac_spi_axis.sv | 114 +++++++++++
 tb/tb_mcp4921_dac_spi_axis.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mcp4921_dac_spi_axis_pkg.sv
// Shared types and frame layout for the MCP4921 SPI DAC bridge.
// Frame = {A/B, BUF, GA_N, SHDN_N, code[11:0]}, sent MSB first.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_LATCH
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CODE_BITS  = 12;

  localparam int BIT_AB   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  function automatic logic [CODE_BITS-1:0] to_code(
    input logic [15:0] d,
    input logic        signed_in
  );
    logic [CODE_BITS-1:0] c;
    if (signed_in) c = {~d[15], d[14:4]};
    else           c = d[11:0];
    return c;
  endfunction

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [CODE_BITS-1:0] code,
    input logic                 buf_bit,
    input logic                 ga_n
  );
    logic [FRAME_BITS-1:0] f;
    f                  = '0;
    f[CODE_BITS-1:0]   = code;
    f[BIT_SHDN]        = 1'b1;
    f[BIT_GA]          = ga_n;
    f[BIT_BUF]         = buf_bit;
    f[BIT_AB]          = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/mcp4921_dac_spi_axis_if.sv
// AXI-Stream sample channel into the DAC bridge.
// Carries one 16-bit sample per tvalid/tready handshake.
interface mcp4921_dac_spi_axis_if;
  import dac_spi_pkg::*;

  logic [FRAME_BITS-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/mcp4921_dac_spi_axis_half_tick.sv
// Half-SPI-period timebase: one-cycle tick every HALF clocks.
// Counter holds at zero while disabled so a new frame starts aligned.
module spi_half_tick #(
  parameter int HALF = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // count while enabled, wrap on tick, restart when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mcp4921_dac_spi_axis.sv
// AXI-Stream sample to MCP4921 SPI frame (mode 0,0) plus LDAC pulse.
// One frame per handshake; ready only while idle, no buffering.
module mcp4921_dac_spi_axis
  import dac_spi_pkg::*;
#(
  parameter int unsigned FCLK      = 50_000_000,
  parameter int unsigned FSCK      = 1_000_000,
  parameter bit          SIGNED_IN = 1'b1,
  parameter bit          BUF       = 1'b0,
  parameter bit          GA_N      = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mcp4921_dac_spi_axis_if.slave        s_axis,
  output logic                         sck,
  output logic                         mosi,
  output logic                         cs,
  output logic                         ldac_n
);

  localparam int HALF = int'(FCLK / (2 * FSCK));

  if (HALF < 2) begin : g_bad_half
    $error("HALF = FCLK/(2*FSCK) must be >= 2");
  end

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic                  ready;
  logic                  tick;
  logic [FRAME_BITS-1:0] frame_in;

  assign frame_in =
    make_frame(to_code(s_axis.tdata, SIGNED_IN), BUF, GA_N);

  assign s_axis.tready = ready;
  assign mosi          = shreg[FRAME_BITS-1];

  spi_half_tick #(
    .HALF (HALF)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != S_IDLE),
    .tick  (tick)
  );

  // frame sequencer: all SPI/LDAC outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      ldac_n  <= 1'b1;
      ready   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (s_axis.tvalid && ready) begin
            shreg   <= frame_in;
            bit_cnt <= '0;
            cs      <= 1'b0;
            ready   <= 1'b0;
            state   <= S_SETUP;
          end else begin
            ready <= 1'b1;
          end
        end
        S_SETUP: begin
          if (tick) begin
            sck     <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (sck) begin
              sck <= 1'b0;
              if (bit_cnt == 5'd16) begin
                cs    <= 1'b1;
                shreg <= '0;
                state <= S_HOLD;
              end else begin
                shreg <= shreg << 1;
              end
            end else begin
              sck     <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            ldac_n <= 1'b0;
            state  <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (tick) begin
            ldac_n <= 1'b1;
            ready  <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp4921_dac_spi_axis.sv
// Directed bench for the MCP4921 bridge: frame words, timing,
// back-to-back streaming and asynchronous reset mid-frame.
module tb_mcp4921_dac_spi_axis;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;

  logic sck_s, mosi_s, cs_s, ldac_s;
  logic sck_u, mosi_u, cs_u, ldac_u;

  mcp4921_dac_spi_axis_if if_s();
  mcp4921_dac_spi_axis_if if_u();

  mcp4921_dac_spi_axis #(.SIGNED_IN(1'b1)) u_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (if_s),
    .sck    (sck_s),
    .mosi   (mosi_s),
    .cs     (cs_s),
    .ldac_n (ldac_s)
  );

  mcp4921_dac_spi_axis #(.SIGNED_IN(1'b0)) u_u (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (if_u),
    .sck    (sck_u),
    .mosi   (mosi_u),
    .cs     (cs_u),
    .ldac_n (ldac_u)
  );

  always #10 clk = ~clk;

  wire m_sck   = sel ? sck_u  : sck_s;
  wire m_mosi  = sel ? mosi_u : mosi_s;
  wire m_cs    = sel ? cs_u   : cs_s;
  wire m_ldac  = sel ? ldac_u : ldac_s;
  wire m_ready = sel ? if_u.tready : if_s.tready;

  typedef struct {
    bit          u;
    bit          tog;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic drv(input logic [15:0] d, input logic v);
    if (sel) begin
      if_u.tdata = d; if_u.tvalid = v;
    end else begin
      if_s.tdata = d; if_s.tvalid = v;
    end
  endtask

  function automatic logic [15:0] model_s(input logic [15:0] d);
    logic [15:0] w;
    w = {4'h3, ~d[15], d[14:4]};
    return w;
  endfunction

  // call right after a negedge; one full frame with timing checks
  task automatic run_frame(input vec_t v);
    logic [15:0] w;
    logic psck, pcs, hm;
    int n, rises, frise, cfall, crise, lfirst, llast, rfirst, bad;
    sel = v.u;
    drv(v.d, 1'b1);
    n = 0;
    while (!m_ready && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("handshake_seen", int'(m_ready), 1);
    if (!m_ready) begin
      drv(v.d, 1'b0);
      return;
    end
    w = '0; psck = 1'b0; pcs = 1'b1; hm = 1'b0;
    rises = 0; frise = -1; cfall = -1; crise = -1;
    lfirst = -1; llast = -1; rfirst = -1; bad = 0;
    for (int k = 1; k <= 900 && rfirst < 0; k++) begin
      @(negedge clk);
      if (m_cs == 1'b0 && pcs && cfall < 0) cfall = k;
      if (m_cs && !pcs) crise = k;
      if (m_sck && !psck) begin
        rises++;
        if (frise < 0) frise = k;
        w = {w[14:0], m_mosi};
        hm = m_mosi;
      end
      if (m_sck && psck && m_mosi !== hm) bad++;
      if (!m_ldac) begin
        if (lfirst < 0) lfirst = k;
        llast = k;
      end
      if (m_ready) rfirst = k;
      psck = m_sck; pcs = m_cs;
      if (v.tog && k < 850) drv(16'($urandom), 1'b1);
      else drv(v.d, 1'b0);
    end
    chk("word", int'(w), int'(v.exp));
    chk("cs_fall", cfall, 1);
    chk("first_sck_rise", frise, 26);
    chk("sck_rises", rises, 16);
    chk("cs_rise", crise, 801);
    chk("ldac_first", lfirst, 826);
    chk("ldac_last", llast, 850);
    chk("tready_back", rfirst, 851);
    chk("mosi_stable_sck_high", bad, 0);
  endtask

  initial begin : main
    logic [15:0] d, w;
    logic psck, pcs, pend;
    int hs[$];
    logic [15:0] sent[$];
    logic [15:0] words[$];
    int cyc, rises, n;

    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h3800};
    vecs[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h3FFF};
    vecs[2] = '{1'b0, 1'b0, 16'h8000, 16'h3000};
    vecs[3] = '{1'b1, 1'b0, 16'hF123, 16'h3123};
    vecs[4] = '{1'b0, 1'b0, 16'h1234, 16'h3923};
    vecs[5] = '{1'b0, 1'b0, 16'hFFF0, 16'h37FF};
    vecs[6] = '{1'b1, 1'b0, 16'h0ABC, 16'h3ABC};
    vecs[7] = '{1'b0, 1'b1, 16'h5A5A, 16'h3DA5};

    if_s.tdata = '0; if_s.tvalid = 1'b0;
    if_u.tdata = '0; if_u.tvalid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs_s & cs_u), 1);
    chk("rst_sck", int'(sck_s | sck_u), 0);
    chk("rst_mosi", int'(mosi_s | mosi_u), 0);
    chk("rst_ldac", int'(ldac_s & ldac_u), 1);
    chk("rst_tready", int'(if_s.tready | if_u.tready), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // tvalid held high, incrementing samples, back-to-back
    sel = 1'b0;
    d = 16'h0100;
    if_s.tdata = d; if_s.tvalid = 1'b1;
    cyc = 0; pend = 1'b0; psck = 1'b0; pcs = 1'b1; w = '0;
    if (if_s.tready) begin
      hs.push_back(cyc); sent.push_back(d); pend = 1'b1;
    end
    for (int i = 0; i < 4000 && words.size() < 3; i++) begin
      @(negedge clk); cyc++;
      if (pend) begin
        d = d + 16'd1; if_s.tdata = d; pend = 1'b0;
      end
      if (if_s.tready) begin
        hs.push_back(cyc); sent.push_back(d); pend = 1'b1;
      end
      if (sck_s && !psck) w = {w[14:0], mosi_s};
      if (cs_s && !pcs) words.push_back(w);
      psck = sck_s; pcs = cs_s;
    end
    if_s.tvalid = 1'b0;
    chk("b2b_frames", int'(words.size()), 3);
    if (hs.size() >= 3 && words.size() >= 3) begin
      chk("b2b_gap0", hs[1] - hs[0], 851);
      chk("b2b_gap1", hs[2] - hs[1], 851);
      for (int i = 0; i < 3; i++)
        chk("b2b_word", int'(words[i]), int'(model_s(sent[i])));
      chk("b2b_seq", int'(sent[2] - sent[0]), 2);
    end else begin
      chk("b2b_handshakes", int'(hs.size()), 3);
    end
    n = 0;
    while (!if_s.tready && n < 2000) begin
      @(negedge clk); n++;
    end

    // asynchronous reset during the high phase of bit 6
    if_s.tdata = 16'h1234; if_s.tvalid = 1'b1;
    n = 0;
    while (!if_s.tready && n < 100) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    if_s.tvalid = 1'b0;
    rises = 0; psck = 1'b0;
    for (int i = 0; i < 600 && rises < 6; i++) begin
      @(negedge clk);
      if (sck_s && !psck) rises++;
      psck = sck_s;
    end
    chk("pre_rst_sck_high", int'(sck_s), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", int'(cs_s), 1);
    chk("midrst_sck", int'(sck_s), 0);
    chk("midrst_ldac", int'(ldac_s), 1);
    chk("midrst_tready", int'(if_s.tready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_tready", int'(if_s.tready), 1);
    run_frame(vecs[2]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
